// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit geometry, flit type decoding and link-tx FSM states.
package noc_pkg;

  localparam int NUM_VC = 4;
  localparam int FLIT_W = 34;
  localparam int VC_W   = $clog2(NUM_VC);

  // Flit field positions
  localparam int TYPE_HI  = 33;
  localparam int TYPE_LO  = 32;
  localparam int ROUTE_HI = 29;
  localparam int ROUTE_LO = 22;
  localparam int ROUTE_W  = ROUTE_HI - ROUTE_LO + 1;

  localparam logic [1:0] FLIT_HEAD = 2'b00;
  localparam logic [1:0] FLIT_TAIL = 2'b11;

  typedef enum logic {
    TX_IDLE   = 1'b0,
    TX_LOCKED = 1'b1
  } tx_state_e;

  // A head is type 00 carrying a non-zero route; type 00 with a zero route is illegal.
  function automatic logic is_head(input logic [1:0] ftype, input logic [ROUTE_W-1:0] route);
    return (ftype == FLIT_HEAD) && (route != '0);
  endfunction

  function automatic logic is_tail(input logic [1:0] ftype);
    return ftype == FLIT_TAIL;
  endfunction

  function automatic logic is_illegal(input logic [1:0] ftype, input logic [ROUTE_W-1:0] route);
    return (ftype == FLIT_HEAD) && (route == '0);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after ptr.
import noc_pkg::*;

module rr_arbiter #(
  parameter int N  = noc_pkg::NUM_VC,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt
);

  logic [PW:0] pos;
  logic        found;

  // Walk the request vector from ptr with wrap-around; first hit wins.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    pos   = '0;
    for (int i = 0; i < N; i++) begin
      pos = {1'b0, ptr} + (PW+1)'(i);
      if (pos >= (PW+1)'(N)) begin
        pos = pos - (PW+1)'(N);
      end
      if (!found && req[pos[PW-1:0]]) begin
        gnt[pos[PW-1:0]] = 1'b1;
        found            = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vc_link_tx.sv
// Link transmitter: packet-granular round-robin over per-VC read ports onto one
// registered valid/ready link.
//
// state     | meaning
// ----------|----------------------------------------------------------
// TX_IDLE   | no packet in flight; arbitrate among VCs showing a HEAD
// TX_LOCKED | link owned by lock_vc until its TAIL is loaded
import noc_pkg::*;

module vc_link_tx #(
  parameter  int NUM_VC = noc_pkg::NUM_VC,
  parameter  int FLIT_W = noc_pkg::FLIT_W,
  localparam int ID_W   = $clog2(NUM_VC)
) (
  input  logic                     clk,
  input  logic                     arst,
  input  logic [NUM_VC*FLIT_W-1:0] fdata_i,
  input  logic [NUM_VC-1:0]        valid_i,
  output logic [NUM_VC-1:0]        ready_o,
  output logic [FLIT_W-1:0]        fdata_o,
  output logic [ID_W-1:0]          vc_id_o,
  output logic                     valid_o,
  input  logic                     ready_i,
  output logic                     err_o
);

  tx_state_e state_q, state_d;

  logic [FLIT_W-1:0]  flit [NUM_VC];
  logic [NUM_VC-1:0]  head_req;
  logic [NUM_VC-1:0]  gnt;
  logic [ID_W-1:0]    win_vc;
  logic [ID_W-1:0]    sel_vc;
  logic [ID_W-1:0]    lock_vc;
  logic [ID_W-1:0]    rr_ptr;
  logic [FLIT_W-1:0]  sel_flit;
  logic [1:0]         sel_type;
  logic [ROUTE_W-1:0] sel_route;
  logic               load;
  logic               sel_ok;
  logic               xfer;
  logic               err_d;

  for (genvar n = 0; n < NUM_VC; n++) begin : g_vc
    assign flit[n]     = fdata_i[n*FLIT_W +: FLIT_W];
    assign head_req[n] = valid_i[n] & is_head(flit[n][TYPE_HI:TYPE_LO], flit[n][ROUTE_HI:ROUTE_LO]);
  end

  rr_arbiter #(
    .N  (NUM_VC),
    .PW (ID_W)
  ) u_arb (
    .req (head_req),
    .ptr (rr_ptr),
    .gnt (gnt)
  );

  // One-hot grant to VC index.
  always_comb begin
    win_vc = '0;
    for (int i = 0; i < NUM_VC; i++) begin
      if (gnt[i]) begin
        win_vc = ID_W'(i);
      end
    end
  end

  // The output register can take a new flit when empty or being drained this cycle.
  assign load      = ~valid_o | ready_i;
  assign sel_vc    = (state_q == TX_IDLE) ? win_vc : lock_vc;
  assign sel_flit  = flit[sel_vc];
  assign sel_type  = sel_flit[TYPE_HI:TYPE_LO];
  assign sel_route = sel_flit[ROUTE_HI:ROUTE_LO];

  // Next-state, candidate selection and protocol-error detection.
  always_comb begin
    state_d = state_q;
    sel_ok  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      TX_IDLE: begin
        if (|head_req) begin
          sel_ok = 1'b1;
          if (load) begin
            state_d = TX_LOCKED;
          end
        end else if (|valid_i) begin
          // Only non-HEAD flits are waiting: they are skipped, never popped.
          err_d = 1'b1;
        end
      end
      TX_LOCKED: begin
        if (valid_i[lock_vc]) begin
          if (is_head(sel_type, sel_route) || is_illegal(sel_type, sel_route)) begin
            // Keep the lock and leave the offending flit in the buffer.
            err_d = 1'b1;
          end else begin
            sel_ok = 1'b1;
            if (load && is_tail(sel_type)) begin
              state_d = TX_IDLE;
            end
          end
        end
      end
      default: state_d = TX_IDLE;
    endcase
  end

  assign xfer = sel_ok & load & ~arst;

  // Pop strobe only toward the VC whose flit is being loaded.
  always_comb begin
    ready_o = '0;
    if (xfer) begin
      ready_o[sel_vc] = 1'b1;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (arst) begin
      state_q <= TX_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Lock owner captured on HEAD load; pointer advances past the owner on TAIL load.
  always_ff @(posedge clk) begin
    if (arst) begin
      lock_vc <= '0;
      rr_ptr  <= '0;
    end else if (xfer) begin
      if (state_q == TX_IDLE) begin
        lock_vc <= win_vc;
      end else if (is_tail(sel_type)) begin
        rr_ptr <= (lock_vc == ID_W'(NUM_VC-1)) ? '0 : lock_vc + ID_W'(1);
      end
    end
  end

  // Output flit register; holds while the downstream stalls.
  always_ff @(posedge clk) begin
    if (arst) begin
      valid_o <= 1'b0;
      fdata_o <= '0;
      vc_id_o <= '0;
    end else if (load) begin
      valid_o <= xfer;
      if (xfer) begin
        fdata_o <= sel_flit;
        vc_id_o <= sel_vc;
      end
    end
  end

  // Error pulse is registered and runs even during a stall.
  always_ff @(posedge clk) begin
    if (arst) begin
      err_o <= 1'b0;
    end else begin
      err_o <= err_d;
    end
  end

endmodule

// File: doc/vc_link_tx.md
# vc_link_tx

Output-side link transmitter for the NoC router. Collects flits from four per-VC buffer read ports and serialises them onto one physical link carrying `fdata_o`/`vc_id_o` under valid/ready. Arbitration is round-robin at packet granularity: a VC that wins on a head flit keeps the link until its tail flit is accepted, so flits from different packets never interleave. Its output is the direct upstream driver of a downstream `vc_buffer` input port.

## Interface
Parameters:
- `NUM_VC`, 4: number of virtual channels; `vc_id_o` width is `$clog2(NUM_VC)`, which is 2.
- `FLIT_W`, 34: flit width; bits [33:32] hold the flit type and bits [29:22] hold the route field.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `arst`  in  1  reset, synchronous and active-high, sampled on `clk`.
- `fdata_i`  in  NUM_VC*FLIT_W  per-VC flits; VC *n* occupies bits [n*34 +: 34].
- `valid_i`  in  NUM_VC  per-VC flit valid.
- `ready_o`  out  NUM_VC  per-VC pop strobe. A flit transfers when `valid_i[n] & ready_o[n]`.
- `fdata_o`  out  FLIT_W  link flit, registered.
- `vc_id_o`  out  2  VC tag of `fdata_o`, registered.
- `valid_o`  out  1  link valid, registered.
- `ready_i`  in  1  downstream ready.
- `err_o`  out  1  protocol-error pulse, one cycle, registered.

## Operation
Flit types, by bits [33:32]:
- HEAD: `2'b00` with route [29:22] != 0.
- BODY: `2'b01` or `2'b10`.
- TAIL: `2'b11`.
- `2'b00` with route == 0 is illegal.

State machine, states IDLE and LOCKED:
- IDLE:
  - Round-robin search over `valid_i`, starting at `rr_ptr`.
  - The first valid VC whose flit is HEAD wins, on condition that the output stage can load.
  - Loading the HEAD moves the FSM to LOCKED with `lock_vc` = winner.
- LOCKED:
  - Only `lock_vc` is eligible.
  - Accepting its TAIL moves the FSM back to IDLE and sets `rr_ptr` = `lock_vc`+1 mod NUM_VC.
  - BODY flits keep the FSM in LOCKED.
- A single-flit packet is not supported. A HEAD must be followed by at least one flit.

Output stage (one flit register):
- `load = ~valid_o | ready_i`.
- `ready_o[n]` is driven high only for the selected VC, and only when `load` is asserted.
- On a transfer: `fdata_o` <= flit, `vc_id_o` <= n, `valid_o` <= 1.
- On `load` with no transfer: `valid_o` <= 0.
- While `valid_o & ~ready_i`: `fdata_o`, `vc_id_o` and `valid_o` hold unchanged.

Protocol errors:
- In IDLE, a valid non-HEAD flit at the front of a VC is skipped by the arbiter and is not popped. `err_o` pulses each cycle it is the only valid candidate.
- In LOCKED, if `lock_vc` presents a HEAD or an illegal flit, the flit is not popped, `err_o` pulses, and the lock holds.

Reset values: `valid_o`=0, `fdata_o`=0, `vc_id_o`=0, `err_o`=0, FSM=IDLE, `rr_ptr`=0, `lock_vc`=0. `ready_o` is combinational and is forced to 0 while `arst`=1.

Reset mid-packet: a partially sent packet is dropped. The FSM returns to IDLE the cycle after `arst` is sampled high, and `valid_o` falls at that same edge.

## Timing
- Latency: a flit popped at edge *k* appears on `fdata_o` in the cycle after edge *k*.
- Throughput: one flit per cycle while `ready_i` stays high.
- `ready_o` depends combinationally on `valid_i`, the flit type bits, FSM state, `valid_o` and `ready_i`. There is no combinational path from `fdata_i` to `fdata_o`.
- Arbitration changes only on a HEAD load (grab) or a TAIL load (release).
- A TAIL loaded at edge *k* allows a new HEAD from a different VC to load at edge *k+1*, giving a back-to-back packet with no bubble.
- A stall with `ready_i`=0 freezes all state except the `err_o` pulse.

## Structure
- Shared package `noc_pkg`:
  - `FLIT_W`, `NUM_VC`, the type localparams `FLIT_HEAD`/`FLIT_TAIL`, and the route slice bounds.
  - Functions `is_head()`, `is_tail()` and `is_illegal()`. These are reused by `vc_buffer`.
- One sub-module, `rr_arbiter`:
  - NUM_VC-wide request vector, with a pointer input and a one-hot grant output.
  - Purely combinational; the pointer register stays in `vc_link_tx`.

## Test plan
1. Single VC, sequential push:
   - Stimulus: VC2 sends HEAD (route 0x05), BODY, TAIL with `ready_i`=1.
   - Required: `fdata_o` shows the three flits on consecutive cycles with `vc_id_o`=2, and `rr_ptr` becomes 3.
2. Packet interleave check:
   - Stimulus: VC0 and VC1 each present 3-flit packets at the same time, starting from `rr_ptr`=0.
   - Required: all 3 VC0 flits go out first, then all 3 VC1 flits. Across the 6 cycles `vc_id_o` reads 0,0,0,1,1,1 with no bubble.
3. Backpressure:
   - Stimulus: hold `ready_i`=0 for 4 cycles mid-packet.
   - Required: `fdata_o`, `vc_id_o` and `valid_o` stay constant, `ready_o`=0, and no flit is lost or duplicated after release.
4. Protocol error:
   - Stimulus: VC3 presents a BODY flit while the FSM is in IDLE and VC3 is the only valid VC.
   - Required: `err_o`=1 each cycle, `ready_o[3]`=0, `valid_o` stays 0.
5. Reset mid-packet:
   - Stimulus: assert `arst` after the HEAD of VC1. After release, present a HEAD on VC0.
   - Required: `valid_o`=0 the cycle after `arst`, the FSM is back in IDLE, and VC0 is granted.
6. Fairness with all VCs busy:
   - Stimulus: all 4 VCs continuously supply 2-flit packets.
   - Required: the grant order is 0,1,2,3,0, with every packet contiguous on the link.
